// File: rtl/aes_inv_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | aes_inv_controller: forward key expansion, then InvRounds NR-1..0  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module aes_inv_controller #(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       new_key,
  output logic       key_load,
  output logic       key_wr_en,
  output logic [3:0] key_idx,
  output logic       state_load,
  output logic       state_en,
  output logic [3:0] round,
  output logic       final_round,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam logic [3:0] c_nr    = 4'(NR);
  localparam logic [3:0] c_nr_m1 = 4'(NR - 1);

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_kexp  = 3'd1;
  localparam logic [2:0] c_init  = 3'd2;
  localparam logic [2:0] c_round = 3'd3;
  localparam logic [2:0] c_done  = 3'd4;

  logic [2:0] r_state;
  logic [2:0] w_next_state;
  logic [3:0] r_round;
  logic [3:0] r_kexp_idx;
  logic       r_key_valid;
  logic       w_accept;
  logic       w_need_kexp;

  assign w_accept    = in_valid && (r_state == c_idle);
  assign w_need_kexp = new_key || !r_key_valid;
  // Only combinational input-to-output path: the key capture strobe.
  assign key_load    = w_accept && new_key;
  assign round       = r_round;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle:  if (w_accept) w_next_state = w_need_kexp ? c_kexp : c_init;
      c_kexp:  if (r_kexp_idx == c_nr) w_next_state = c_init;
      c_init:  w_next_state = c_round;
      c_round: if (r_round == 4'd0) w_next_state = c_done;
      c_done:  if (out_ready) w_next_state = c_idle;
      default: w_next_state = c_idle;
    endcase
  end

  // Round keys are written 1..NR; K[0] arrives via key_load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_round     <= 4'd0;
      r_kexp_idx  <= 4'd0;
      r_key_valid <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_accept && w_need_kexp) r_kexp_idx <= 4'd1;
        end
        c_kexp: begin
          if (r_kexp_idx == c_nr) begin
            r_key_valid <= 1'b1;
            r_kexp_idx  <= 4'd0;
          end else begin
            r_kexp_idx  <= r_kexp_idx + 4'd1;
          end
        end
        c_init:  r_round <= c_nr_m1;
        c_round: if (r_round != 4'd0) r_round <= r_round - 4'd1;
        c_done:  if (out_ready) r_round <= 4'd0;
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready    = 1'b0;
    key_wr_en   = 1'b0;
    key_idx     = 4'd0;
    state_load  = 1'b0;
    state_en    = 1'b0;
    final_round = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      c_idle: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      c_kexp: begin
        key_wr_en = 1'b1;
        key_idx   = r_kexp_idx;
      end
      c_init: begin
        state_load = 1'b1;
        state_en   = 1'b1;
        key_idx    = c_nr;
      end
      c_round: begin
        state_en    = 1'b1;
        key_idx     = r_round;
        final_round = (r_round == 4'd0);
      end
      c_done: begin
        // State register frozen so plaintext survives back-pressure.
        out_valid = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/aes_inv_controller.md
Name: aes_inv_controller

Overview:
- FSM that sequences the AES inverse cipher (decryption) datapath. It is the decrypt-side counterpart of the encryption round controller.
- Because decryption consumes round keys in reverse order, it runs a forward key-expansion pass into the datapath's key store whenever a new key is presented or none is cached.
- It then issues the initial AddRoundKey with K[NR], followed by InvRounds NR-1 down to 0. Round 0 skips InvMixColumns.
- It sits between the decrypt input/output ready/valid handshakes and the inverse round datapath plus key store.

Parameters:
- NR, 10, number of cipher rounds; legal values 10, 12, 14 (4-bit counters).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  ciphertext block (and optional key) present
- in_ready  out  1  controller can accept a block
- new_key  in  1  qualified by in_valid&&in_ready; key on the datapath input is new and must be expanded
- key_load  out  1  datapath captures input key as K[0]
- key_wr_en  out  1  key store writes expanded round key at key_idx
- key_idx  out  4  key store write index (KEXP) or read index (INIT/ROUND)
- state_load  out  1  state register selects ciphertext input instead of round output
- state_en  out  1  state register update enable
- round  out  4  current inverse round number
- final_round  out  1  datapath bypasses InvMixColumns
- out_valid  out  1  plaintext valid on datapath output
- out_ready  in  1  downstream accepts plaintext
- busy  out  1  high in every state except IDLE

Behaviour:
- States: IDLE, KEXP, INIT, ROUND, DONE.
- Registers: state, round, kexp_idx[3:0], key_valid.
- Reset (async): state=IDLE, round=0, kexp_idx=0, key_valid=0.
  - Reset outputs: key_load, key_wr_en, state_load, state_en, final_round, out_valid, busy = 0; key_idx=0.
  - in_ready = 1, since it is a decode of IDLE.
- accept = in_valid && in_ready.
- IDLE: in_ready=1.
  - On accept: key_load = new_key. The ciphertext is held by the datapath input register, not by this block.
  - Next state is KEXP if new_key || !key_valid, otherwise INIT.
  - On entry to KEXP, kexp_idx <= 1.
  - in_valid without accept has no effect.
- KEXP: key_wr_en=1, key_idx=kexp_idx; kexp_idx increments each cycle.
  - When kexp_idx==NR: key_valid <= 1 and next state is INIT.
  - Lasts exactly NR cycles.
- INIT: state_load=1, state_en=1, key_idx=NR (AddRoundKey with K[NR]).
  - round <= NR-1; next state ROUND.
- ROUND: state_en=1, key_idx=round.
  - round>0: final_round=0; round decrements.
  - round==0: final_round=1; next state DONE; round holds at 0.
- DONE: out_valid=1, held stable until out_ready is sampled high.
  - Then next state IDLE, round <= 0.
  - No state_en in DONE: plaintext stays stable under back-pressure.
- Latency, accept edge = cycle 0:
  - cached key: INIT in cycle 1, ROUND in cycles 2..NR+1, out_valid from cycle NR+2.
  - new key: +NR cycles.
- Throughput: one block at a time; in_ready=0 from the cycle after accept until return to IDLE.
  - No accept in the same cycle as the DONE handshake; IDLE is re-entered first.
- new_key while key_valid=1 forces re-expansion. key_valid is cleared only by reset.
- Reset mid-operation: immediate return to IDLE, key_valid cleared. The next block always re-expands, regardless of new_key.
- All outputs are decoded from registered state/counters only, with no combinational path from inputs to outputs.
  - Exception: key_load = accept && new_key, which is combinational from in_valid and new_key.
- Counter arithmetic is 4-bit unsigned. round never wraps below 0, and kexp_idx never exceeds NR.

Test Plan:
- Reset then check: all outputs 0 except in_ready=1; busy=0; round=0.
- First block after reset with new_key=0, NR=10:
  - goes through KEXP anyway; key_wr_en high 10 cycles with key_idx 1..10;
  - INIT with key_idx=10;
  - rounds 9..0 with final_round only at round 0;
  - out_valid at cycle 22.
- Second block with new_key=0 and out_ready=1: no KEXP; out_valid at cycle 12; key_idx sequence 10,9,...,0.
- Back-pressure: out_ready=0 for 5 cycles in DONE.
  - out_valid stays 1, state_en=0, in_ready=0.
  - Return to IDLE the cycle after out_ready=1.
- in_valid held high throughout a busy block: exactly one accept per completed block; in_ready=0 while busy.
- rst_n pulsed low during ROUND with round=5: immediate IDLE.
  - The next block with new_key=0 still performs KEXP.
- NR=14 build with new_key=1: KEXP lasts 14 cycles; INIT key_idx=14; out_valid at cycle 30.
